// File: rtl/gat_pkg.sv
// Shared constants and types for the GAT datapath.
// Vector geometry and the storer FSM state type live here so loader and storer stay in step.
package gat_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int VEC_DEPTH  = 16;
  localparam int VEC_IDX_W  = (VEC_DEPTH > 1) ? $clog2(VEC_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } storer_state_e;

endpackage

// File: rtl/vec_bram_storer.sv
// Captures one flattened vector on a valid/ready handshake and writes its elements,
// one per cycle, into a BRAM write port starting at the sampled base address.
module vec_bram_storer
  import gat_pkg::*;
#(
  parameter int  VEC_DEPTH  = gat_pkg::VEC_DEPTH,
  parameter int  DATA_WIDTH = gat_pkg::DATA_WIDTH,
  parameter int  ADDR_W     = 8,
  localparam int IDX_W      = (VEC_DEPTH > 1) ? $clog2(VEC_DEPTH) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            vec_vld_i,
  output logic                            vec_rdy_o,
  input  logic [VEC_DEPTH*DATA_WIDTH-1:0] vec_flat_i,
  input  logic [ADDR_W-1:0]               base_addr_i,
  input  logic                            wr_stall_i,
  output logic                            bram_ena,
  output logic                            bram_wea,
  output logic [ADDR_W-1:0]               bram_addra,
  output logic [DATA_WIDTH-1:0]           bram_dina,
  output logic                            done_o
);

  storer_state_e         state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]     base_q;
  logic [DATA_WIDTH-1:0] vec_q [VEC_DEPTH];
  logic                  capture;
  logic                  write_go;

  assign capture  = (state_q == IDLE) && vec_vld_i;
  assign write_go = (state_q == WRITE) && !wr_stall_i;

  // Datapath registers only load on the handshake; the upstream is free to change afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      for (int k = 0; k < VEC_DEPTH; k++) begin
        vec_q[k] <= '0;
      end
    end else if (capture) begin
      base_q <= base_addr_i;
      for (int k = 0; k < VEC_DEPTH; k++) begin
        vec_q[k] <= vec_flat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (vec_vld_i) begin
          state_d = WRITE;
          idx_d   = '0;
        end
      end
      WRITE: begin
        if (!wr_stall_i) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(VEC_DEPTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and data follow idx_q, so they naturally hold their value across a stall.
  always_comb begin
    vec_rdy_o  = (state_q == IDLE);
    done_o     = (state_q == DONE);
    bram_ena   = write_go;
    bram_wea   = write_go;
    bram_addra = base_q + ADDR_W'(idx_q);
    bram_dina  = vec_q[idx_q];
  end

endmodule

// File: tb/tb_vec_bram_storer.sv
// Self-checking bench for vec_bram_storer: queue-based write model checked every cycle,
// plus directed scenarios with hand-computed latencies and address ranges.
module tb_vec_bram_storer;

  localparam int VD = 16;
  localparam int DW = 8;
  localparam int AW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vec_vld_i;
  logic             vec_rdy_o;
  logic [VD*DW-1:0] vec_flat_i;
  logic [AW-1:0]    base_addr_i;
  logic             wr_stall_i;
  logic             bram_ena;
  logic             bram_wea;
  logic [AW-1:0]    bram_addra;
  logic [DW-1:0]    bram_dina;
  logic             done_o;

  always #5 clk = ~clk;

  vec_bram_storer #(.VEC_DEPTH(VD), .DATA_WIDTH(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vec_vld_i  (vec_vld_i),
    .vec_rdy_o  (vec_rdy_o),
    .vec_flat_i (vec_flat_i),
    .base_addr_i(base_addr_i),
    .wr_stall_i (wr_stall_i),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .done_o     (done_o)
  );

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int dutDoneCount = 0;
  int lastDoneCyc = 0;
  logic [DW-1:0] memArr [256];
  int wcount [256];
  bit stallRand = 1'b0;
  bit stallForce = 1'b0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t expQ[$];
  int  phase = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: idle / writing a queue of (addr,data) / one done cycle.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("reset rdy", vec_rdy_o, 1);
        checkOutput("reset ena", bram_ena, 0);
        checkOutput("reset wea", bram_wea, 0);
        checkOutput("reset done", done_o, 0);
        checkOutput("reset addr", bram_addra, 0);
        checkOutput("reset dina", bram_dina, 0);
      end else begin
        case (phase)
          0: begin
            checkOutput("idle rdy", vec_rdy_o, 1);
            checkOutput("idle ena", bram_ena, 0);
            checkOutput("idle wea", bram_wea, 0);
            checkOutput("idle done", done_o, 0);
          end
          1: begin
            checkOutput("write rdy", vec_rdy_o, 0);
            checkOutput("write done", done_o, 0);
            checkOutput("write ena", bram_ena, !wr_stall_i);
            checkOutput("write wea", bram_wea, !wr_stall_i);
            if (!wr_stall_i) begin
              if (expQ.size() == 0) checkOutput("model queue empty", 0, 1);
              else begin
                checkOutput("write addr", bram_addra, expQ[0].addr);
                checkOutput("write data", bram_dina, expQ[0].data);
              end
            end
          end
          default: begin
            checkOutput("done rdy", vec_rdy_o, 0);
            checkOutput("done pulse", done_o, 1);
            checkOutput("done ena", bram_ena, 0);
            checkOutput("done wea", bram_wea, 0);
          end
        endcase
      end
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        phase = 0;
        expQ.delete();
      end else begin
        case (phase)
          0: if (vec_vld_i) begin
            for (int k = 0; k < VD; k++) begin
              w.addr = AW'((int'(base_addr_i) + k) % 256);
              w.data = vec_flat_i[k*DW +: DW];
              expQ.push_back(w);
            end
            phase = 1;
          end
          1: if (!wr_stall_i && expQ.size() > 0) begin
            void'(expQ.pop_front());
            if (expQ.size() == 0) phase = 2;
          end
          default: phase = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bram_ena && bram_wea) begin
      memArr[bram_addra] = bram_dina;
      wcount[bram_addra]++;
    end
    if (rst_n && done_o) begin
      dutDoneCount++;
      lastDoneCyc = cyc + 1;
    end
  end

  always @(posedge clk) begin
    #3;
    wr_stall_i = stallRand ? ($urandom_range(0, 3) == 0) : stallForce;
  end

  function automatic logic [VD*DW-1:0] randVec();
    logic [VD*DW-1:0] v;
    for (int k = 0; k < VD; k++) v[k*DW +: DW] = DW'($urandom());
    return v;
  endfunction

  function automatic logic [VD*DW-1:0] seqVec(input int start);
    logic [VD*DW-1:0] v;
    for (int k = 0; k < VD; k++) v[k*DW +: DW] = DW'(start + k);
    return v;
  endfunction

  task automatic clearMem();
    for (int a = 0; a < 256; a++) begin
      wcount[a] = 0;
      memArr[a] = '0;
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] base, input logic [VD*DW-1:0] flat,
                               input bit keepVld, output int hsCyc);
    bit got = 1'b0;
    @(posedge clk); #2;
    vec_vld_i   = 1'b1;
    base_addr_i = base;
    vec_flat_i  = flat;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (vec_rdy_o === 1'b1) got = 1'b1;
      @(posedge clk); #2;
    end
    hsCyc = cyc;
    if (!got) checkOutput("handshake timeout", 0, 1);
    vec_vld_i   = keepVld;
    vec_flat_i  = randVec();
    base_addr_i = AW'($urandom());
  endtask

  task automatic waitDone(input int startCount);
    int n = 0;
    while (dutDoneCount == startCount && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (dutDoneCount == startCount) checkOutput("done timeout", 0, 1);
  endtask

  task automatic checkRange(input string name, input int base, input logic [VD*DW-1:0] flat);
    int total = 0;
    for (int k = 0; k < VD; k++) begin
      checkOutput({name, " count"}, wcount[(base + k) % 256], 1);
      checkOutput({name, " data"}, memArr[(base + k) % 256], flat[k*DW +: DW]);
    end
    for (int a = 0; a < 256; a++) total += wcount[a];
    checkOutput({name, " total writes"}, total, VD);
  endtask

  initial begin
    int hs, hs2, d0, doneBase;
    logic [VD*DW-1:0] v, v2;
    rst_n = 1'b0; vec_vld_i = 1'b0; vec_flat_i = '0; base_addr_i = '0; wr_stall_i = 1'b0;
    clearMem();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset rdy", vec_rdy_o, 1);
    checkOutput("post-reset ena", bram_ena, 0);
    checkOutput("post-reset done", done_o, 0);

    // Basic store
    $display("[TB] basic store");
    v = seqVec(1);
    d0 = dutDoneCount;
    applyStimulus(8'h10, v, 1'b0, hs);
    waitDone(d0);
    checkOutput("basic done latency", lastDoneCyc - hs, 17);
    @(negedge clk);
    checkOutput("basic rdy return", vec_rdy_o, 1);
    checkOutput("basic rdy cycle", cyc + 1 - hs, 18);
    checkOutput("basic first elem", memArr[8'h10], 8'h01);
    checkOutput("basic last elem", memArr[8'h1F], 8'h10);
    checkRange("basic", 8'h10, v);

    // Stall after the 5th write
    $display("[TB] stall mid-vector");
    clearMem();
    d0 = dutDoneCount;
    applyStimulus(8'h10, v, 1'b0, hs);
    repeat (5) @(posedge clk);
    #2 stallForce = 1'b1;
    @(negedge clk);
    checkOutput("stall ena low", bram_ena, 0);
    checkOutput("stall addr held", bram_addra, 8'h15);
    repeat (3) @(posedge clk);
    #2 stallForce = 1'b0;
    waitDone(d0);
    checkOutput("stall done latency", lastDoneCyc - hs, 20);
    checkRange("stall", 8'h10, v);

    // Address wrap
    $display("[TB] address wrap");
    clearMem();
    v = randVec();
    d0 = dutDoneCount;
    applyStimulus(8'hF8, v, 1'b0, hs);
    waitDone(d0);
    checkOutput("wrap addr 0x07", memArr[8'h07], v[15*DW +: DW]);
    checkOutput("wrap addr 0xF7 untouched", wcount[8'hF7], 0);
    checkOutput("wrap addr 0x08 untouched", wcount[8'h08], 0);
    checkRange("wrap", 8'hF8, v);

    // Back-to-back with valid held high
    $display("[TB] back-to-back");
    clearMem();
    v  = seqVec(8'h01);
    v2 = seqVec(8'hA0);
    d0 = dutDoneCount;
    applyStimulus(8'h10, v, 1'b1, hs);
    applyStimulus(8'h40, v2, 1'b0, hs2);
    checkOutput("b2b handshake spacing", hs2 - hs, 18);
    waitDone(d0 + 1);
    checkOutput("b2b second data", memArr[8'h40], 8'hA0);
    checkOutput("b2b second last", memArr[8'h4F], 8'hAF);
    checkOutput("b2b first data", memArr[8'h10], 8'h01);
    checkOutput("b2b done count", dutDoneCount - d0, 2);

    // Reset after the 7th write
    $display("[TB] reset mid-write");
    clearMem();
    d0 = dutDoneCount;
    applyStimulus(8'h60, randVec(), 1'b0, hs);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid-reset ena", bram_ena, 0);
    checkOutput("mid-reset rdy", vec_rdy_o, 1);
    checkOutput("mid-reset done", done_o, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    checkOutput("mid-reset partial writes", wcount[8'h66], 1);
    checkOutput("mid-reset abandoned", wcount[8'h67], 0);
    checkOutput("mid-reset no done", dutDoneCount, d0);
    clearMem();
    v = randVec();
    applyStimulus(8'h80, v, 1'b0, hs);
    waitDone(d0);
    checkRange("after reset", 8'h80, v);

    // Randomized traffic with random stalls and gaps
    $display("[TB] random traffic");
    stallRand = 1'b1;
    doneBase = dutDoneCount;
    for (int n = 0; n < 25; n++) begin
      bit keep;
      keep = ($urandom_range(0, 3) == 0) && (n != 24);
      applyStimulus(AW'($urandom()), randVec(), keep, hs);
      if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    waitDone(doneBase + 24);
    repeat (5) @(posedge clk);
    checkOutput("random done count", dutDoneCount - doneBase, 25);
    stallRand = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/vec_bram_storer.md
Name: vec_bram_storer

Overview:
- Write-side counterpart of the vector loader path.
- Accepts one flattened vector of VEC_DEPTH elements through a valid/ready handshake and captures it into an internal register array.
- Writes the elements one per cycle into a single-port BRAM write port, starting at a per-vector base address.
- Used to commit per-node results (e.g. attention/feature outputs) back into BRAM for later reload.

Parameters:
- VEC_DEPTH, 16: number of elements per vector.
- DATA_WIDTH, 8: element width in bits. Taken from gat_pkg.
- ADDR_W, 8: BRAM address width.
- IDX_W, $clog2(VEC_DEPTH): element index width. Derived; not overridden.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- vec_vld_i  input  1  upstream vector valid.
- vec_rdy_o  output  1  storer can accept a vector.
- vec_flat_i  input  VEC_DEPTH*DATA_WIDTH  flattened vector; element k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- base_addr_i  input  ADDR_W  BRAM address for element 0; sampled with the vector.
- wr_stall_i  input  1  downstream backpressure; pauses writes.
- bram_ena  output  1  BRAM port enable.
- bram_wea  output  1  BRAM write enable.
- bram_addra  output  ADDR_W  BRAM write address.
- bram_dina  output  DATA_WIDTH  BRAM write data.
- done_o  output  1  one-cycle pulse after the last element is written.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, idx=0, vec_reg=0, base_reg=0, done_o=0, bram_ena=0, bram_wea=0, bram_addra=0, bram_dina=0. vec_rdy_o=1 out of reset because it is decoded from the IDLE state.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - vec_rdy_o=1; all BRAM strobes are 0.
  - On vec_vld_i && vec_rdy_o at edge T: capture vec_flat_i into vec_reg and base_addr_i into base_reg, clear idx, and go to WRITE.
  - The upstream must hold data only until the handshake; the input is not re-sampled afterwards.
- WRITE:
  - vec_rdy_o=0.
  - When wr_stall_i=0: bram_ena=bram_wea=1, bram_addra=base_reg+idx, bram_dina=vec_reg[idx].
  - At the edge, idx increments. If idx==VEC_DEPTH-1, go to DONE.
  - When wr_stall_i=1: ena=wea=0, idx holds, addra/dina keep their previous values (don't-care for checking).
- DONE:
  - done_o=1 for exactly one cycle, vec_rdy_o=0, strobes 0.
  - Next state is IDLE.
- Outputs are decoded combinationally from registered state only. There is no combinational path from vec_vld_i or vec_flat_i to any BRAM output.
- Latency with no stall:
  - Handshake at edge T.
  - Writes occupy cycles T+1 .. T+VEC_DEPTH.
  - done_o is high in cycle T+VEC_DEPTH+1.
  - vec_rdy_o returns high in cycle T+VEC_DEPTH+2.
  - Each stall cycle during WRITE extends all of these by one.
- Address arithmetic: base_reg+idx is computed in ADDR_W bits and wraps modulo 2^ADDR_W. There is no error flag.
- wr_stall_i is ignored in IDLE and DONE.
- vec_vld_i asserted while not ready is ignored; the upstream holds it until it sees ready.
- VEC_DEPTH=1: exactly one write cycle, then DONE.
- Reset asserted mid-WRITE: immediate return to the reset values. A partial vector is abandoned (no done_o). Elements already written remain in the BRAM.
- Each element is written exactly once per vector. No duplicate or skipped addresses, including across stalls.

Decomposition:
- gat_pkg gains VEC_DEPTH, VEC_IDX_W and the storer state enum type (IDLE/WRITE/DONE), alongside the existing DATA_WIDTH.
- No sub-module required. The element mux (vec_reg[idx]) stays inline as a generate/indexed select.
- Optional sub-module if preferred: vec_bram_wr_ctrl, holding the FSM and the idx/address counter, separated from the datapath register.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high -> vec_rdy_o=1, all BRAM strobes 0, done_o=0.
- Basic store: VEC_DEPTH=16, base=0x10, elements 0x01..0x10, no stall -> writes go to 0x10..0x1F with data 0x01..0x10 on 16 consecutive cycles. done_o pulses once at T+17; vec_rdy_o=1 at T+18.
- Stall mid-vector: same vector, wr_stall_i high for 3 cycles after the 5th write -> no strobes during the stall; writes 6..16 resume at address 0x15 with no gaps or duplicates; done_o is at T+20.
- Address wrap: base=0xF8, ADDR_W=8 -> addresses 0xF8..0xFF, then 0x00..0x07.
- Back-to-back vectors: vec_vld_i held high with a second vector (base 0x40) -> the second handshake occurs only in the first IDLE cycle after DONE; writes to 0x40..0x4F carry the second vector's data; the first vector is not re-captured.
- Reset mid-write: rst_n asserted after the 7th write -> strobes drop immediately, no done_o; after release, vec_rdy_o=1 and a new vector stores correctly from its element 0.
